// File: rtl/des_dec_keysched_pkg.sv
// des_pkg: shared DES key-schedule definitions.
//   - PC1 (64->56) and PC2 (56->48) selection tables, FIPS 1-based bit numbers
//   - SHIFT: per-round left-shift amounts of the encrypt schedule
//   - subkey_t / half_t / round_t, FSM state type
//   - pc1()   : applies PC1 to a 64-bit key (bit 63 = FIPS bit 1)
//   - rotr()  : right rotate of a 28-bit half by 1 or 2
//   - rotl()  : left rotate, only present with DES_KS_ENCRYPT_EN
// Bit order everywhere: MSB = FIPS bit 1, so C = cd[55:28], D = cd[27:0].
package des_pkg;

   typedef logic [47:0] subkey_t;
   typedef logic [27:0] half_t;
   typedef logic [3:0]  round_t;

   typedef enum logic {KS_IDLE = 1'b0, KS_GEN = 1'b1} ks_state_t;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Parity bits (FIPS 8,16,..,64) are simply never selected.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
      return r;
   endfunction

   function automatic half_t rotr(input half_t h, input logic two);
      return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
   endfunction

`ifdef DES_KS_ENCRYPT_EN
   function automatic half_t rotl(input half_t h, input logic two);
      return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
   endfunction
`endif

endpackage

// File: rtl/des_dec_keysched_if.sv
// des_dec_keysched_if: key-in / subkey-out handshake bundle.
//   key/key_valid/key_ready : key load channel
//   sk/sk_round/sk_last/sk_valid/sk_ready : subkey stream channel
//   mode : only with DES_KS_ENCRYPT_EN (1 = encrypt order K1..K16)
// Modports: slave = key schedule block, master = key source / subkey consumer.
interface des_dec_keysched_if;
   import des_pkg::*;

   logic [63:0] key;
   logic        key_valid;
   logic        key_ready;
   subkey_t     sk;
   round_t      sk_round;
   logic        sk_last;
   logic        sk_valid;
   logic        sk_ready;
`ifdef DES_KS_ENCRYPT_EN
   logic        mode;

   modport slave  (input  key, key_valid, sk_ready, mode,
                   output key_ready, sk, sk_round, sk_last, sk_valid);
   modport master (output key, key_valid, sk_ready, mode,
                   input  key_ready, sk, sk_round, sk_last, sk_valid);
`else
   modport slave  (input  key, key_valid, sk_ready,
                   output key_ready, sk, sk_round, sk_last, sk_valid);
   modport master (output key, key_valid, sk_ready,
                   input  key_ready, sk, sk_round, sk_last, sk_valid);
`endif

endinterface

// File: rtl/des_dec_keysched_pc2.sv
// des_pc2: combinational PC2 selection, 56-bit {C,D} -> 48-bit subkey.
//   cd : {C,D}, bit 55 = FIPS bit 1
//   sk : subkey, bit 47 = FIPS bit 1
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0] cd,
   output subkey_t     sk
);

   for (genvar i = 0; i < 48; i++) begin : g_bit
      assign sk[47-i] = cd[56-PC2[i]];
   end

   // PC2 drops 8 of the 56 bits by definition.
   logic unused_cd;
   assign unused_cd = ^cd;

endmodule

// File: rtl/des_dec_keysched.sv
// des_dec_keysched: DES key schedule streaming subkeys K16..K1 (decrypt order),
// one per clock while the consumer accepts.
//   clk   : clock, all state on posedge
//   reset : synchronous, active low
//   ks    : des_dec_keysched_if.slave (key channel in, subkey stream out)
// Parameter ALLOW_RELOAD: accept the next key during the final subkey beat so
// streams run back-to-back.
// Macro DES_KS_ENCRYPT_EN: adds ks.mode; mode=1 at key accept streams K1..K16
// using left rotates.
module des_dec_keysched
   import des_pkg::*;
#(
   parameter bit ALLOW_RELOAD = 1'b0
)(
   input  logic              clk,
   input  logic              reset,
   des_dec_keysched_if.slave ks
);

   ks_state_t   state, state_nxt;
   half_t       c, d, c_nxt, d_nxt;
   subkey_t     sk_q, sk_nxt;
   round_t      rnd, rnd_nxt;
   logic        last, last_nxt, vld, vld_nxt;
   logic        hs, load, key_rdy, sk_upd;
   logic [55:0] cd_key;
`ifdef DES_KS_ENCRYPT_EN
   logic        enc, enc_nxt;
`endif

   assign hs      = vld & ks.sk_ready;
   assign key_rdy = (state == KS_IDLE) ||
                    (ALLOW_RELOAD && (state == KS_GEN) && hs && last);
   assign load    = ks.key_valid & key_rdy;
   assign cd_key  = pc1(ks.key);
   // The final beat never rotates: sk_round must not wrap past the end.
   assign sk_upd  = load | (hs & ~last);

   always_ff @(posedge clk) begin
      if (!reset) state <= KS_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load)             state_nxt = KS_GEN;
      else if (hs && last)  state_nxt = KS_IDLE;
   end

   always_comb begin
      c_nxt    = c;
      d_nxt    = d;
      rnd_nxt  = rnd;
      last_nxt = last;
      vld_nxt  = vld;
`ifdef DES_KS_ENCRYPT_EN
      enc_nxt  = enc;
`endif
      if (load) begin
         // C0,D0 equal C16,D16, so K16 comes straight from PC1(key).
         c_nxt    = cd_key[55:28];
         d_nxt    = cd_key[27:0];
         rnd_nxt  = 4'd15;
         last_nxt = 1'b0;
         vld_nxt  = 1'b1;
`ifdef DES_KS_ENCRYPT_EN
         enc_nxt  = ks.mode;
         if (ks.mode) begin
            c_nxt   = rotl(cd_key[55:28], SHIFT[0] == 2);
            d_nxt   = rotl(cd_key[27:0],  SHIFT[0] == 2);
            rnd_nxt = 4'd0;
         end
`endif
      end else if (hs && last) begin
         vld_nxt = 1'b0;
      end else if (hs) begin
`ifdef DES_KS_ENCRYPT_EN
         if (enc) begin
            c_nxt    = rotl(c, SHIFT[rnd + 4'd1] == 2);
            d_nxt    = rotl(d, SHIFT[rnd + 4'd1] == 2);
            rnd_nxt  = rnd + 4'd1;
            last_nxt = (rnd == 4'd14);
         end else begin
`endif
            c_nxt    = rotr(c, SHIFT[rnd] == 2);
            d_nxt    = rotr(d, SHIFT[rnd] == 2);
            rnd_nxt  = rnd - 4'd1;
            last_nxt = (rnd == 4'd1);
`ifdef DES_KS_ENCRYPT_EN
         end
`endif
      end
   end

   des_pc2 u_pc2 (
      .cd ({c_nxt, d_nxt}),
      .sk (sk_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         c    <= '0;
         d    <= '0;
         sk_q <= '0;
         rnd  <= '0;
         last <= 1'b0;
         vld  <= 1'b0;
`ifdef DES_KS_ENCRYPT_EN
         enc  <= 1'b0;
`endif
      end else begin
         vld <= vld_nxt;
`ifdef DES_KS_ENCRYPT_EN
         enc <= enc_nxt;
`endif
         if (sk_upd) begin
            c    <= c_nxt;
            d    <= d_nxt;
            sk_q <= sk_nxt;
            rnd  <= rnd_nxt;
            last <= last_nxt;
         end
      end
   end

   assign ks.key_ready = key_rdy;
   assign ks.sk        = sk_q;
   assign ks.sk_round  = rnd;
   assign ks.sk_last   = last;
   assign ks.sk_valid  = vld;

endmodule

// File: tb/tb_des_dec_keysched.sv
// tb_des_dec_keysched: directed bench for des_dec_keysched.
// u_dut runs with ALLOW_RELOAD=0, u_rl with ALLOW_RELOAD=1; both share clk/reset.
// Expected subkeys are the published FIPS example values for key
// 133457799BBCDFF1 plus hand-derived PC2(PC1(key)) for 0E329232EA6D0D73.
module tb_des_dec_keysched;
   import des_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   des_dec_keysched_if ks0 ();
   des_dec_keysched_if ks1 ();

   des_dec_keysched #(.ALLOW_RELOAD(1'b0)) u_dut (.clk(clk), .reset(reset), .ks(ks0));
   des_dec_keysched #(.ALLOW_RELOAD(1'b1)) u_rl  (.clk(clk), .reset(reset), .ks(ks1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
   localparam logic [47:0] B_K16 = 48'h606F044C3AE7;

   // Key A subkeys in decrypt order: K16 first, K1 last.
   logic [47:0] ka [16];
   logic [47:0] exp_sk [16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string p, input int b, input logic [47:0] e_sk,
                           input logic [3:0] e_rnd, input logic e_last);
      chk($sformatf("%s_vld%0d", p, b),   {63'd0, ks0.sk_valid}, 64'd1);
      chk($sformatf("%s_sk%0d", p, b),    {16'd0, ks0.sk},       {16'd0, e_sk});
      chk($sformatf("%s_rnd%0d", p, b),   {60'd0, ks0.sk_round}, {60'd0, e_rnd});
      chk($sformatf("%s_last%0d", p, b),  {63'd0, ks0.sk_last},  {63'd0, e_last});
   endtask

   // Loads k on u_dut and walks all 16 beats against exp_sk, optionally with
   // consumer stalls; every stalled cycle re-checks the held outputs.
   task automatic stream(input string p, input logic [63:0] k, input bit stalls, input bit enc);
      ks0.key       = k;
      ks0.key_valid = 1'b1;
      ks0.sk_ready  = 1'b1;
      step();
      ks0.key_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         int ns;
         ns = 0;
         if (stalls) ns = (b == 3 || b == 10) ? 5 : int'($urandom_range(2, 0));
         for (int s = 0; s <= ns; s++) begin
            chk_beat(p, b, exp_sk[b], enc ? 4'(b) : 4'(15 - b), b == 15);
            ks0.sk_ready = (s == ns);
            step();
         end
      end
      ks0.sk_ready = 1'b1;
      chk({p, "_end_vld"},  {63'd0, ks0.sk_valid},  64'd0);
      chk({p, "_end_krdy"}, {63'd0, ks0.key_ready}, 64'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      ka = '{48'hCB3D8B0E17F5, 48'hBF918D3D3F0A, 48'h5F43B7F2E73A, 48'h97C5D1FABA41,
             48'h7571F59467E9, 48'h215FD3DED386, 48'hB1F347BA464F, 48'hE0DBEBEDE781,
             48'hF78A3AC13BFB, 48'hEC84B7F618BC, 48'h63A53E507B2F, 48'h7CEC07EB53A8,
             48'h72ADD6DB351D, 48'h55FC8A42CF99, 48'h79AED9DBC9E5, 48'h1B02EFFC7072};
      reset = 1'b0;
      ks0.key = '0; ks0.key_valid = 1'b0; ks0.sk_ready = 1'b1;
      ks1.key = '0; ks1.key_valid = 1'b0; ks1.sk_ready = 1'b1;
`ifdef DES_KS_ENCRYPT_EN
      ks0.mode = 1'b0;
      ks1.mode = 1'b0;
`endif

      // Reset state
      step();
      step();
      chk("rst_vld",  {63'd0, ks0.sk_valid}, 64'd0);
      chk("rst_sk",   {16'd0, ks0.sk},       64'd0);
      chk("rst_rnd",  {60'd0, ks0.sk_round}, 64'd0);
      chk("rst_last", {63'd0, ks0.sk_last},  64'd0);
      reset = 1'b1;
      step();
      chk("rst_krdy",    {63'd0, ks0.key_ready}, 64'd1);
      chk("rst_krdy_rl", {63'd0, ks1.key_ready}, 64'd1);

      // Key A, consumer always ready
      for (int i = 0; i < 16; i++) exp_sk[i] = ka[i];
      stream("a", KEY_A, 1'b0, 1'b0);

      // Key A with stalls
      stream("a_stall", KEY_A, 1'b1, 1'b0);

      // All-zero and all-one keys
      for (int i = 0; i < 16; i++) exp_sk[i] = 48'h0;
      stream("zero", 64'h0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) exp_sk[i] = 48'hFFFFFFFFFFFF;
      stream("ones", 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);

      // Reset during beat 7 aborts the stream
      ks0.key = KEY_A; ks0.key_valid = 1'b1; ks0.sk_ready = 1'b1;
      step();
      ks0.key_valid = 1'b0;
      for (int b = 0; b < 7; b++) step();
      chk("mid_rnd7", {60'd0, ks0.sk_round}, 64'd8);
      reset = 1'b0;
      step();
      chk("mid_rst_vld", {63'd0, ks0.sk_valid}, 64'd0);
      chk("mid_rst_sk",  {16'd0, ks0.sk},       64'd0);
      chk("mid_rst_rnd", {60'd0, ks0.sk_round}, 64'd0);
      reset = 1'b1;
      step();
      chk("mid_idle_vld",  {63'd0, ks0.sk_valid},  64'd0);
      chk("mid_idle_krdy", {63'd0, ks0.key_ready}, 64'd1);
      step();
      chk("mid_idle_vld2", {63'd0, ks0.sk_valid}, 64'd0);
      for (int i = 0; i < 16; i++) exp_sk[i] = ka[i];
      stream("after_rst", KEY_A, 1'b0, 1'b0);

      // Back-to-back reload on u_rl: A then B, no bubble
      ks1.key = KEY_A; ks1.key_valid = 1'b1; ks1.sk_ready = 1'b1;
      step();
      ks1.key = KEY_B;
      for (int b = 0; b < 16; b++) begin
         chk($sformatf("rl_a_vld%0d", b),  {63'd0, ks1.sk_valid},  64'd1);
         chk($sformatf("rl_a_sk%0d", b),   {16'd0, ks1.sk},        {16'd0, ka[b]});
         chk($sformatf("rl_a_rnd%0d", b),  {60'd0, ks1.sk_round},  64'(15 - b));
         chk($sformatf("rl_a_krdy%0d", b), {63'd0, ks1.key_ready}, 64'(b == 15));
         step();
      end
      ks1.key_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         chk($sformatf("rl_b_vld%0d", b), {63'd0, ks1.sk_valid}, 64'd1);
         chk($sformatf("rl_b_rnd%0d", b), {60'd0, ks1.sk_round}, 64'(15 - b));
         if (b == 0) chk("rl_b_k16", {16'd0, ks1.sk}, {16'd0, B_K16});
         step();
      end
      chk("rl_end_vld", {63'd0, ks1.sk_valid}, 64'd0);

`ifdef DES_KS_ENCRYPT_EN
      // Encrypt order: K1..K16
      for (int i = 0; i < 16; i++) exp_sk[i] = ka[15-i];
      ks0.mode = 1'b1;
      stream("enc", KEY_A, 1'b1, 1'b1);
      ks0.mode = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
